// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one 32-bit word per line.
// Hits are served combinationally in IDLE; misses go through WRITEBACK (if dirty) and FETCH.
module data_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  read,
  input  logic [2:0]  write,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic [3:0]  mem_read,
  output logic [2:0]  mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  req_ld, req_st, access, hit;

  assign idx     = address[INDEX_BITS+1:2];
  assign req_tag = address[31:INDEX_BITS+2];
  assign req_ld  = read[3] & ~write[2];
  assign req_st  = write[2] & ~read[3];
  assign access  = req_ld | req_st;
  assign hit     = valid[idx] && (tag_arr[idx] == req_tag);

  // Select the addressed lane(s) and extend according to funct3.
  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  // Merge right-aligned store data into the addressed lanes of the old word.
  function automatic logic [31:0] store_merge(input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic [31:0] old_word,
                                              input logic [31:0] wdata);
    logic [31:0] r;
    r = old_word;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Control state: FSM, valid and dirty bits are the only reset state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_st && hit) begin
        dirty[idx] <= 1'b1;
      end else if (state == FETCH && !mem_busywait) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clock) begin
    if (state == IDLE && req_st && hit) begin
      data_arr[idx] <= store_merge(write[1:0], address[1:0], data_arr[idx], writedata);
    end else if (state == FETCH && !mem_busywait) begin
      data_arr[idx] <= mem_readdata;
      tag_arr[idx]  <= req_tag;
    end
  end

  always_comb begin
    state_next    = state;
    mem_read      = 4'b0000;
    mem_write     = 3'b000;
    mem_address   = 32'd0;
    mem_writedata = 32'd0;
    case (state)
      IDLE: begin
        if (access && !hit)
          state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        mem_write     = 3'b110;
        mem_address   = {tag_arr[idx], idx, 2'b00};
        mem_writedata = data_arr[idx];
        if (!mem_busywait) state_next = FETCH;
      end
      FETCH: begin
        mem_read    = 4'b1010;
        mem_address = {address[31:2], 2'b00};
        if (!mem_busywait) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gate with reset so the CPU sees an idle cache the moment reset asserts.
  assign busywait = reset && access && ((state != IDLE) || !hit);
  assign readdata = (reset && state == IDLE && req_ld && hit)
                    ? load_extend(read[2:0], address[1:0], data_arr[idx]) : 32'd0;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a small word-addressed memory model.
module tb_data_cache;

  logic        clock;
  logic        reset;
  logic [3:0]  read;
  logic [2:0]  write;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int checks = 0;
  int errors = 0;

  int          bcnt, rcnt, wcnt;
  logic [31:0] raddr, waddr, wdata;
  logic        done;

  logic [31:0] mem [64];

  data_cache #(.INDEX_BITS(3)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents are (re)loaded while reset is low; accepted word writes update it.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[4]  <= 32'hDEADBEEF;
      mem[12] <= 32'h11223344;
      mem[20] <= 32'hCAFEF00D;
    end else if (mem_write == 3'b110 && !mem_busywait) begin
      mem[mem_address[7:2]] <= mem_writedata;
    end
  end

  assign mem_readdata = mem[mem_address[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a request is applied at a falling edge; returns at the
  // first sample point where busywait is low, recording memory traffic on the way.
  task automatic run_miss();
    bcnt = 0; rcnt = 0; wcnt = 0;
    raddr = 32'd0; waddr = 32'd0; wdata = 32'd0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (busywait) begin
        bcnt++;
        if (mem_read == 4'b1010) begin rcnt++; raddr = mem_address; end
        if (mem_write == 3'b110) begin wcnt++; waddr = mem_address; wdata = mem_writedata; end
        @(negedge clock);
      end else begin
        done = 1'b1;
      end
    end
    chk("miss_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; read = 4'b1010; write = 3'b000;
    address = 32'h10; writedata = 32'd0; mem_busywait = 1'b0;

    // Reset state, with a load request present
    repeat (2) @(negedge clock);
    #1;
    chk("rst_busywait", {31'd0, busywait}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_mem_read", {28'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {29'd0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    read = 4'b0000;
    @(negedge clock);
    reset = 1'b1;

    // Cold clean miss: LW 0x10
    @(negedge clock);
    read = 4'b1010; address = 32'h10;
    run_miss();
    chk("cold_busy_cycles", bcnt, 32'd2);
    chk("cold_read_cycles", rcnt, 32'd1);
    chk("cold_read_addr", raddr, 32'h10);
    chk("cold_write_cycles", wcnt, 32'd0);
    chk("cold_readdata", readdata, 32'hDEADBEEF);

    // SW hit, then sub-word loads
    @(negedge clock);
    read = 4'b0000; write = 3'b110; address = 32'h10; writedata = 32'h80FF7F01;
    #1 chk("sw_busywait", {31'd0, busywait}, 32'd0);
    @(negedge clock);
    write = 3'b000; read = 4'b1000; address = 32'h13;
    #1 chk("lb_13", readdata, 32'hFFFFFF80);
    chk("lb_busywait", {31'd0, busywait}, 32'd0);
    read = 4'b1100; #1 chk("lbu_13", readdata, 32'h00000080);
    read = 4'b1001; address = 32'h12; #1 chk("lh_12", readdata, 32'hFFFF80FF);
    address = 32'h13; #1 chk("lh_13_a0_ignored", readdata, 32'hFFFF80FF);
    read = 4'b1101; address = 32'h10; #1 chk("lhu_10", readdata, 32'h00007F01);
    read = 4'b1000; address = 32'h10; #1 chk("lb_10", readdata, 32'h00000001);
    read = 4'b1011; #1 chk("reserved_full_word", readdata, 32'h80FF7F01);
    chk("hit_busywait", {31'd0, busywait}, 32'd0);
    read = 4'b0000; #1 chk("no_access_readdata", readdata, 32'd0);

    // SB 0xAB to 0x11 (upper writedata bits must be ignored)
    @(negedge clock);
    write = 3'b100; address = 32'h11; writedata = 32'h123456AB;
    #1 chk("sb_busywait", {31'd0, busywait}, 32'd0);
    chk("sb_no_mem_write", {29'd0, mem_write}, 32'd0);
    @(negedge clock);
    write = 3'b000; read = 4'b1010; address = 32'h10;
    #1 chk("lw_after_sb", readdata, 32'h80FFAB01);
    chk("sb_no_mem_traffic", {25'd0, mem_read, mem_write}, 32'd0);

    // Dirty miss: LW 0x30 evicts 0x10
    @(negedge clock);
    address = 32'h30;
    run_miss();
    chk("dirty_busy_cycles", bcnt, 32'd3);
    chk("dirty_write_cycles", wcnt, 32'd1);
    chk("dirty_write_addr", waddr, 32'h10);
    chk("dirty_write_data", wdata, 32'h80FFAB01);
    chk("dirty_read_addr", raddr, 32'h30);
    chk("dirty_readdata", readdata, 32'h11223344);
    chk("mem_after_writeback", mem[4], 32'h80FFAB01);

    // FETCH stalled by mem_busywait
    @(negedge clock);
    address = 32'h50; mem_busywait = 1'b1;
    #1 chk("stall_idle_busywait", {31'd0, busywait}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      chk("stall_mem_read", {28'd0, mem_read}, 32'h0000000A);
      chk("stall_mem_address", mem_address, 32'h50);
      chk("stall_busywait", {31'd0, busywait}, 32'd1);
    end
    mem_busywait = 1'b0;
    @(negedge clock);
    #1 chk("stall_fill_busywait", {31'd0, busywait}, 32'd0);
    chk("stall_fill_readdata", readdata, 32'hCAFEF00D);

    // Simultaneous read and write enables: no access
    @(negedge clock);
    read = 4'b1010; write = 3'b110; address = 32'h50; writedata = 32'hFFFFFFFF;
    #1 chk("both_busywait", {31'd0, busywait}, 32'd0);
    chk("both_mem_req", {25'd0, mem_read, mem_write}, 32'd0);
    chk("both_readdata", readdata, 32'd0);
    @(negedge clock);
    write = 3'b000;
    #1 chk("both_array_unchanged", readdata, 32'hCAFEF00D);

    // Reset during WRITEBACK
    @(negedge clock);
    read = 4'b0000; write = 3'b110; address = 32'h50; writedata = 32'h12345678;
    #1 chk("pre_rst_sw_busywait", {31'd0, busywait}, 32'd0);
    @(negedge clock);
    write = 3'b000; read = 4'b1010; address = 32'h10; mem_busywait = 1'b1;
    #1 chk("pre_rst_idle_mem_write", {29'd0, mem_write}, 32'd0);
    @(negedge clock);
    #1 chk("wb_mem_write", {29'd0, mem_write}, 32'h00000006);
    chk("wb_mem_address", mem_address, 32'h50);
    chk("wb_mem_writedata", mem_writedata, 32'h12345678);
    reset = 1'b0;
    #1 chk("rst_wb_mem_write", {29'd0, mem_write}, 32'd0);
    chk("rst_wb_busywait", {31'd0, busywait}, 32'd0);
    chk("rst_wb_mem_address", mem_address, 32'd0);
    chk("rst_wb_readdata", readdata, 32'd0);
    read = 4'b0000; mem_busywait = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    read = 4'b1010; address = 32'h50;
    run_miss();
    chk("post_rst_busy_cycles", bcnt, 32'd2);
    chk("post_rst_write_cycles", wcnt, 32'd0);
    chk("post_rst_read_addr", raddr, 32'h50);
    chk("post_rst_readdata", readdata, 32'hCAFEF00D);

    @(negedge clock);
    read = 4'b0000;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
